// File: rtl/onset_bpm_estimator.sv
// Onset-to-BPM estimator.
// Measures the interval between accepted onset rising edges in milliseconds,
// keeps the last up-to-4 plausible intervals and converts their mean into
// beats-per-minute with a sequential restoring divider:
//   bpm = floor(60000 * fill / sum(history))
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no reference onset yet; first edge starts the interval timer
// MEASURE | timing the current interval; accept, ignore or time out
// DIVIDE  | history updated; one load cycle then 18 quotient-bit cycles
module onset_bpm_estimator #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int MIN_INTERVAL_MS = 250,
  parameter int MAX_INTERVAL_MS = 1500,
  parameter int BPM_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 onset,
  output logic [BPM_WIDTH-1:0] bpm,
  output logic                 bpm_valid,
  output logic                 beat,
  output logic                 locked
);

  localparam int PRE_MAX = CLK_FREQ / 1000 - 1;
  localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int MS_W    = $clog2(MAX_INTERVAL_MS + 1);
  localparam int SUM_W   = 15;
  localparam int DVD_W   = 18;
  localparam int REM_W   = SUM_W + 1;
  localparam int EXT_W   = (DVD_W > BPM_WIDTH) ? DVD_W : BPM_WIDTH;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_MAX);
  localparam logic [MS_W-1:0]  MIN_MS   = MS_W'(MIN_INTERVAL_MS);
  localparam logic [MS_W-1:0]  MAX_MS   = MS_W'(MAX_INTERVAL_MS);
  localparam logic [EXT_W-1:0] BPM_MAX  = EXT_W'({BPM_WIDTH{1'b1}});

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  state_t            state;
  logic              onset_q;
  logic [PRE_W-1:0]  prescaler;
  logic [MS_W-1:0]   ms_cnt;
  logic [MS_W-1:0]   hist [4];
  logic [2:0]        fill;
  logic              div_load;
  logic [4:0]        iter;
  logic [REM_W-1:0]  rem;
  logic [DVD_W-1:0]  quo;
  logic [SUM_W-1:0]  divisor;

  logic              evt;
  logic              tick;
  logic              ms_at_max;
  logic              start;
  logic              accept;
  logic              timer_clr;
  logic [SUM_W-1:0]  sum;
  logic [DVD_W-1:0]  dividend;
  logic [REM_W-1:0]  rem_sh;
  logic              rem_ge;
  logic [EXT_W-1:0]  quo_ext;
  logic [BPM_WIDTH-1:0] bpm_next;

  // Event decode and timer-clear decisions for the current cycle.
  always_comb begin
    evt       = onset & ~onset_q;
    tick      = (prescaler == PRE_LAST);
    ms_at_max = (ms_cnt == MAX_MS);
    start     = evt && ((state == IDLE) || ((state == MEASURE) && ms_at_max));
    accept    = evt && (state == MEASURE) && !ms_at_max && (ms_cnt >= MIN_MS);
    timer_clr = start | accept;
  end

  // History sum, dividend select, divider step and output saturation.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + SUM_W'(hist[i]);
    end
    case (fill)
      3'd1:    dividend = 18'd60000;
      3'd2:    dividend = 18'd120000;
      3'd3:    dividend = 18'd180000;
      default: dividend = 18'd240000;
    endcase
    rem_sh  = {rem[REM_W-2:0], quo[DVD_W-1]};
    rem_ge  = (rem_sh >= {1'b0, divisor});
    quo_ext = EXT_W'(quo);
    if (quo_ext > BPM_MAX) begin
      bpm_next = {BPM_WIDTH{1'b1}};
    end else begin
      bpm_next = quo_ext[BPM_WIDTH-1:0];
    end
  end

  // Millisecond timer: prescaler tick, saturating ms count, cleared on accepted events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      ms_cnt    <= '0;
    end else if (timer_clr) begin
      prescaler <= '0;
      ms_cnt    <= '0;
    end else if (tick) begin
      prescaler <= '0;
      if (!ms_at_max) ms_cnt <= ms_cnt + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Control FSM with history, divider and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      onset_q   <= 1'b0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      fill      <= '0;
      div_load  <= 1'b0;
      iter      <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      bpm       <= '0;
      bpm_valid <= 1'b0;
      beat      <= 1'b0;
      locked    <= 1'b0;
    end else begin
      onset_q   <= onset;
      beat      <= 1'b0;
      bpm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (evt) begin
            beat  <= 1'b1;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (ms_at_max) begin
            // Loss of lock; an edge landing on the timeout restarts from scratch.
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            fill   <= '0;
            locked <= 1'b0;
            if (evt) begin
              beat  <= 1'b1;
              state <= MEASURE;
            end else begin
              state <= IDLE;
            end
          end else if (accept) begin
            beat    <= 1'b1;
            hist[0] <= ms_cnt;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            if (fill != 3'd4) fill <= fill + 1'b1;
            div_load <= 1'b1;
            state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_load) begin
            // History and fill settled last cycle; snapshot operands.
            div_load <= 1'b0;
            rem      <= '0;
            quo      <= dividend;
            divisor  <= sum;
            iter     <= 5'd18;
          end else if (iter != '0) begin
            rem  <= rem_ge ? (rem_sh - {1'b0, divisor}) : rem_sh;
            quo  <= {quo[DVD_W-2:0], rem_ge};
            iter <= iter - 1'b1;
          end else begin
            bpm       <= bpm_next;
            bpm_valid <= 1'b1;
            locked    <= 1'b1;
            state     <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onset_bpm_estimator.sv
// Directed bench for onset_bpm_estimator at CLK_FREQ=1000 (1 cycle = 1 ms).
// Detection edges N cycles apart measure an interval of N-1 ms (timer is
// cleared on the accepting edge and counts whole elapsed ticks after it).
module tb_onset_bpm_estimator;

  logic        clk = 1'b0;
  logic        reset;
  logic        onset;
  logic [15:0] bpm;
  logic        bpm_valid;
  logic        beat;
  logic        locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t;
  int nb;

  always #5 clk = ~clk;

  onset_bpm_estimator #(
    .CLK_FREQ(1000),
    .MIN_INTERVAL_MS(250),
    .MAX_INTERVAL_MS(1500),
    .BPM_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .onset(onset),
    .bpm(bpm),
    .bpm_valid(bpm_valid),
    .beat(beat),
    .locked(locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Raise onset so it is detected at edge t; onset is left high.
  task automatic fire_at(input int tt, input logic exp_beat, input string tag);
    while (cyc < tt - 1) step();
    onset = 1'b1;
    step();
    chk({tag, "_beat"}, beat, exp_beat);
  endtask

  task automatic wait_to(input int tt, output int nbeat);
    nbeat = 0;
    while (cyc < tt) begin
      step();
      if (beat === 1'b1) nbeat++;
    end
  endtask

  // Called right after an accepting edge: bpm_valid exactly 20 cycles later.
  task automatic check_valid(input int exp_bpm, input string tag);
    int early;
    early = 0;
    repeat (19) begin
      step();
      if (bpm_valid === 1'b1 || beat === 1'b1) early++;
    end
    step();
    chk({tag, "_early"}, early, 0);
    chk({tag, "_valid"}, bpm_valid, 1);
    chk({tag, "_bpm"}, bpm, exp_bpm);
    chk({tag, "_locked"}, locked, 1);
    step();
    chk({tag, "_pulse1"}, bpm_valid, 0);
  endtask

  task automatic check_no_valid(input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n) begin
      step();
      if (bpm_valid === 1'b1) seen++;
    end
    chk({tag, "_novalid"}, seen, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0;
    onset = 1'b0;
    repeat (3) step();
    chk("rst_bpm", bpm, 0);
    chk("rst_valid", bpm_valid, 0);
    chk("rst_beat", beat, 0);
    chk("rst_locked", locked, 0);
    reset = 1'b1;
    step();

    // Two onsets 500 apart: interval 499 -> 60000/499 = 120
    t = cyc + 10;
    fire_at(t, 1'b1, "s1_first");  onset = 1'b0;
    chk("s1_unlocked", locked, 0);
    check_no_valid(20, "s1_idle");
    t += 500;
    fire_at(t, 1'b1, "s1_second"); onset = 1'b0;
    check_valid(120, "s1");

    // Spacing 500,500,600,400,600 -> 499,499,599,399,599
    do_reset();
    t = cyc + 5;
    fire_at(t, 1'b1, "s2_start"); onset = 1'b0;
    t += 500; fire_at(t, 1'b1, "s2_i1"); onset = 1'b0; check_valid(120, "s2_i1"); // 60000/499
    t += 500; fire_at(t, 1'b1, "s2_i2"); onset = 1'b0; check_valid(120, "s2_i2"); // 120000/998
    t += 600; fire_at(t, 1'b1, "s2_i3"); onset = 1'b0; check_valid(112, "s2_i3"); // 180000/1597
    t += 400; fire_at(t, 1'b1, "s2_i4"); onset = 1'b0; check_valid(120, "s2_i4"); // 240000/1996
    t += 600; fire_at(t, 1'b1, "s2_i5"); onset = 1'b0; check_valid(114, "s2_i5"); // 240000/2096

    // Held onset: one beat only. History 599,399,599,499 -> 240000/2096
    t += 500;
    fire_at(t, 1'b1, "s3_held");
    check_valid(114, "s3_held");
    wait_to(t + 300, nb);
    chk("s3_held_extra_beats", nb, 0);
    onset = 1'b0;
    // History 399,599,499,499 -> 240000/1996
    t += 500; fire_at(t, 1'b1, "s3_next"); onset = 1'b0; check_valid(120, "s3_next");
    fire_at(t + 100, 1'b0, "s3_glitch"); onset = 1'b0;
    wait_to(t + 599, nb);
    chk("s3_glitch_beats", nb, 0);
    // Measured from t, not the glitch: 599 -> 599,499,499,599 -> 240000/2196
    t += 600; fire_at(t, 1'b1, "s3_orig"); onset = 1'b0; check_valid(109, "s3_orig");

    // Loss of lock 1501 edges after the last accept
    wait_to(t + 1500, nb);
    chk("s4_quiet_beats", nb, 0);
    chk("s4_locked_before", locked, 1);
    step();
    chk("s4_locked_after", locked, 0);
    chk("s4_bpm_hold", bpm, 109);
    t += 1600;
    fire_at(t, 1'b1, "s4_restart"); onset = 1'b0;
    chk("s4_restart_unlocked", locked, 0);
    check_no_valid(20, "s4_restart");
    t += 750; fire_at(t, 1'b1, "s4_relock"); onset = 1'b0; check_valid(80, "s4_relock"); // 60000/749

    // MIN boundary: 249 ignored, 251 and 250 accepted
    fire_at(t + 250, 1'b0, "min_249"); onset = 1'b0;
    t += 252; fire_at(t, 1'b1, "min_251"); onset = 1'b0; check_valid(120, "min_251"); // 120000/1000
    t += 251; fire_at(t, 1'b1, "min_250"); onset = 1'b0; check_valid(144, "min_250"); // 180000/1250

    // Reset 10 cycles into DIVIDE
    t += 600; fire_at(t, 1'b1, "s6_accept"); onset = 1'b0;
    repeat (10) step();
    reset = 1'b0;
    #1;
    chk("s6_rst_bpm", bpm, 0);
    chk("s6_rst_valid", bpm_valid, 0);
    chk("s6_rst_beat", beat, 0);
    chk("s6_rst_locked", locked, 0);
    repeat (3) step();
    reset = 1'b1;
    check_no_valid(30, "s6_aborted");
    t = cyc + 5;
    fire_at(t, 1'b1, "s6_after"); onset = 1'b0;
    chk("s6_after_unlocked", locked, 0);
    check_no_valid(25, "s6_after");

    // MAX boundary: 1499 accepted; 1500 is a timeout plus fresh start
    t += 1500; fire_at(t, 1'b1, "max_1499"); onset = 1'b0; check_valid(40, "max_1499"); // 60000/1499
    t += 1501; fire_at(t, 1'b1, "max_1500"); onset = 1'b0;
    chk("max_1500_unlocked", locked, 0);
    check_no_valid(20, "max_1500");
    chk("max_1500_bpm_hold", bpm, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
